// File: rtl/jam_ctrl_pkg.sv
// Shared constants, state encoding and permutation helper for the JAM sequencing controller.
package jam_pkg;

  localparam int unsigned N_W    = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned COST_W = 7;
  localparam int unsigned SUM_W  = 10;

  localparam logic [SUM_W-1:0]       MIN_INIT  = 10'h3FF;
  localparam logic [N_W*IDX_W-1:0]   LAST_PERM = 24'o76543210;
  localparam logic [3:0]             MATCH_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SETTLE,
    ST_FETCH,
    ST_LAST,
    ST_CMP,
    ST_NEXT,
    ST_WAIT,
    ST_DONE
  } jam_state_t;

  // Worker 0 occupies the most significant index field.
  function automatic logic [IDX_W-1:0] job_of(input logic [N_W*IDX_W-1:0] vec,
                                              input logic [IDX_W-1:0]       idx);
    return vec[(N_W - 1 - int'(idx)) * IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/jam_ctrl_if.sv
// Permutation-generator handshake and cost-memory bus seen by the JAM controller.
interface jam_ctrl_if;

  logic [2:0]                                    perm_init;
  logic                                          perm_start;
  logic                                          perm_fin;
  logic [jam_pkg::N_W*jam_pkg::IDX_W-1:0]        perm_vec;
  logic [jam_pkg::IDX_W-1:0]                     W;
  logic [jam_pkg::IDX_W-1:0]                     J;
  logic [jam_pkg::COST_W-1:0]                    Cost;

  modport master (
    output perm_init, perm_start, W, J,
    input  perm_fin, perm_vec, Cost
  );

  modport slave (
    input  perm_init, perm_start, W, J,
    output perm_fin, perm_vec, Cost
  );

endinterface

// File: rtl/jam_ctrl_min_tracker.sv
// Running minimum of permutation totals and saturating count of permutations that hit it.
module jam_min_tracker #(
  parameter int unsigned SUM_W = jam_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] min_cost,
  output logic [3:0]       match_count
);
  import jam_pkg::*;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_cost    <= SUM_W'(MIN_INIT);
      match_count <= '0;
    end else if (update) begin
      if (sum < min_cost) begin
        min_cost    <= sum;
        match_count <= 4'd1;
      end else if (sum == min_cost && match_count != MATCH_MAX) begin
        match_count <= match_count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/jam_ctrl.sv
// JAM sequencing controller: steps the permutation generator, sums the 8 costs per
// permutation from a one-cycle-latency cost memory and tracks the minimum total.
module jam_ctrl #(
  parameter int unsigned N_W    = jam_pkg::N_W,
  parameter int unsigned COST_W = jam_pkg::COST_W,
  parameter int unsigned SUM_W  = jam_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  jam_ctrl_if.master       bus,
  output logic [SUM_W-1:0] MinCost,
  output logic [3:0]       MatchCount,
  output logic             Valid
);
  import jam_pkg::*;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_W - 1);

  jam_state_t       state;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] w_q;
  logic [IDX_W-1:0] j_q;
  logic [SUM_W-1:0] sum;
  logic             start_q;
  logic             init_q;
  logic             valid_q;
  logic             cmp_stage;
  logic [COST_W-1:0] cost_word;

  assign cost_word = bus.Cost;
  assign cmp_stage = (state == ST_CMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      k       <= '0;
      w_q     <= '0;
      j_q     <= '0;
      sum     <= '0;
      start_q <= 1'b0;
      init_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      init_q  <= 1'b0;
      case (state)
        ST_INIT: begin
          init_q <= 1'b1;
          state  <= ST_SETTLE;
        end
        // Address for k=0 is registered on FETCH entry so the memory sees it during the first FETCH cycle.
        ST_SETTLE, ST_WAIT: begin
          if (state == ST_SETTLE || bus.perm_fin) begin
            k     <= '0;
            sum   <= '0;
            w_q   <= '0;
            j_q   <= job_of(bus.perm_vec, '0);
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (k != '0) sum <= sum + SUM_W'(cost_word);
          if (k == K_LAST) begin
            state <= ST_LAST;
          end else begin
            k   <= k + IDX_W'(1);
            w_q <= k + IDX_W'(1);
            j_q <= job_of(bus.perm_vec, k + IDX_W'(1));
          end
        end
        ST_LAST: begin
          sum   <= sum + SUM_W'(cost_word);
          state <= ST_CMP;
        end
        ST_CMP: begin
          if (bus.perm_vec == LAST_PERM) begin
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            start_q <= 1'b1;
            state   <= ST_NEXT;
          end
        end
        ST_NEXT: state <= ST_WAIT;
        ST_DONE: state <= ST_DONE;
        default: state <= ST_INIT;
      endcase
    end
  end

  jam_min_tracker #(
    .SUM_W(SUM_W)
  ) u_min (
    .clk         (clk),
    .rst         (rst),
    .update      (cmp_stage),
    .sum         (sum),
    .min_cost    (MinCost),
    .match_count (MatchCount)
  );

  assign bus.perm_init  = {2'b00, init_q};
  assign bus.perm_start = start_q;
  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign Valid          = valid_q;

endmodule
